// File: rtl/polar_pkg.sv
// Shared types and helpers for the polar encoder/decoder schedulers.
package polar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the per-frame stage-count field: counts 0..log2(n) inclusive.
    function automatic int unsigned cfg_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    // Insert a 0 at bit position pos of k; yields the lo index of pair k in stage pos.
    function automatic int unsigned insert_zero(input int unsigned k, input int unsigned pos);
        int unsigned low_mask;
        low_mask = (32'd1 << pos) - 32'd1;
        return ((k & ~low_mask) << 1) | (k & low_mask);
    endfunction

endpackage

// File: rtl/polar_enc_sched_if.sv
// Frame-in / codeword-out handshake bundle of the polar encoder scheduler.
interface polar_enc_sched_if
    import polar_pkg::*;
#(
    parameter int N = 16
);
    localparam int CW = cfg_width(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [CW-1:0] cfg_log_n;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    // Frame producer / codeword consumer side.
    modport master (
        output in_valid, in_data, cfg_log_n, out_ready,
        input  in_ready, out_valid, out_data
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_data, cfg_log_n, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/polar_enc_sched_base.sv
// Two-input polar butterfly cell: x_hi = sel ? u_lo ^ u_hi : u_hi, x_lo = u_lo.
module PolarBase (
    input  logic u_lo,
    input  logic u_hi,
    input  logic sel,
    output logic x_lo,
    output logic x_hi
);

    assign x_lo = u_lo;
    assign x_hi = sel ? (u_lo ^ u_hi) : u_hi;

endmodule

// File: rtl/polar_enc_sched.sv
// Polar encoder scheduler: latches one frame, runs log2(N) butterfly stages
// P pairs per cycle through a bank of PolarBase cells, then offers the result.
module polar_enc_sched
    import polar_pkg::*;
#(
    parameter int N = 16,
    parameter int P = 4
) (
    input  logic             clk,
    input  logic             rst,
    polar_enc_sched_if.slave bus,
    output logic             busy
);

    localparam int LOGN = $clog2(N);
    localparam int BPS  = N / (2 * P);
    localparam int CW   = cfg_width(N);
    localparam int SW   = CW;
    localparam int BW   = (BPS > 1) ? $clog2(BPS) : 1;

    state_t        state;
    state_t        state_next;

    logic [N-1:0]  x;
    logic [N-1:0]  x_next;
    logic [SW-1:0] s;
    logic [BW-1:0] b;
    logic [CW-1:0] nact;
    logic [CW-1:0] nact_in;

    logic          last_b;
    logic          last_s;
    logic          sel;

    logic [LOGN-1:0] lo_idx [P];
    logic [LOGN-1:0] hi_idx [P];
    logic [P-1:0]    u_lo;
    logic [P-1:0]    u_hi;
    logic [P-1:0]    x_lo;
    logic [P-1:0]    x_hi;

    assign last_b  = (b == BW'(BPS - 1));
    assign last_s  = (s == SW'(LOGN - 1));
    assign sel     = (s < nact);
    assign nact_in = (bus.cfg_log_n > CW'(LOGN)) ? CW'(LOGN) : bus.cfg_log_n;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (last_b && last_s) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the state register and the frame register only.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.out_data  = (state == DONE) ? x : '0;
        busy          = (state != IDLE);
    end

    // Pair index decode for batch b of stage s, and operand fetch from the frame.
    always_comb begin
        int unsigned k;
        int unsigned lo;
        k  = 0;
        lo = 0;
        for (int unsigned j = 0; j < P; j++) begin
            k         = 32'(b) * 32'(P) + j;
            lo        = insert_zero(k, 32'(s));
            lo_idx[j] = LOGN'(lo);
            hi_idx[j] = LOGN'(lo + (32'd1 << s));
            u_lo[j]   = x[lo_idx[j]];
            u_hi[j]   = x[hi_idx[j]];
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_cell
        PolarBase u_cell (
            .u_lo (u_lo[g]),
            .u_hi (u_hi[g]),
            .sel  (sel),
            .x_lo (x_lo[g]),
            .x_hi (x_hi[g])
        );
    end

    // Write-back mux: pairs in one batch are disjoint, so the writes never collide.
    always_comb begin
        x_next = x;
        for (int unsigned j = 0; j < P; j++) begin
            x_next[lo_idx[j]] = x_lo[j];
            x_next[hi_idx[j]] = x_hi[j];
        end
    end

    // Frame register, stage/batch counters and active-stage count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            s    <= '0;
            b    <= '0;
            nact <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x    <= bus.in_data;
                        nact <= nact_in;
                        s    <= '0;
                        b    <= '0;
                    end
                end
                RUN: begin
                    x <= x_next;
                    if (last_b) begin
                        b <= '0;
                        s <= s + SW'(1);
                    end else begin
                        b <= b + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
